step_clock_ctrl: RTL



---
 rtl/step_clock_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/step_clock_ctrl.sv
// rtl/step_clock_ctrl.sv - free-run / single-step clock generator for the instruction fetch unit
// Optional STEP_BURST_EN: each accepted button press issues BURST_LEN back-to-back steps.
module step_clock_ctrl #(
  parameter int DIV_COUNT  = 50000000,
  parameter int DEB_CYCLES = 1000000,
  parameter int PULSE_LEN  = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RunMode,
  input  logic        StepBtn,
  output logic        ClkOut,
  output logic        Tick,
  output logic [15:0] StepCount,
  output logic        Busy
);
  localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PUL_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  if (DIV_COUNT < 2 * PULSE_LEN + 2 || BURST_LEN < 1 || DEB_CYCLES < 1) begin : g_param_check
    $error("step_clock_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, HIGH, GUARD} state_t;
  state_t state, state_next;

  logic             run_meta, run_sync, run_prev, btn_meta, btn_sync;
  logic             stable, stable_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [PUL_W-1:0] ph_cnt;
  logic [15:0]      step_cnt;
  logic             pending, pending_next;
  logic             clk_out, tick;
  logic             mode_change, run_trig, step_trig, trig, start, ph_done;
`ifdef STEP_BURST_EN
  localparam int BUR_W = $clog2(BURST_LEN + 1);
  logic [BUR_W-1:0] burst_left, burst_next;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
      run_prev <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      run_meta <= RunMode;
      run_sync <= run_meta;
      run_prev <= run_sync;
      btn_meta <= StepBtn;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: the level is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      stable_prev <= stable;
      if (btn_sync == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        stable  <= ~stable;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign mode_change = run_sync ^ run_prev;
  assign run_trig    = (div_cnt == DIV_W'(DIV_COUNT - 1));
  assign step_trig   = stable & ~stable_prev;
  assign trig        = run_sync ? (run_trig & ~mode_change) : step_trig;
  assign ph_done     = (ph_cnt == PUL_W'(PULSE_LEN - 1));

  always_ff @(posedge Clk) begin
    if (Reset || mode_change || run_trig) div_cnt <= '0;
    else                                  div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    state_next   = state;
    pending_next = pending;
    start        = 1'b0;
`ifdef STEP_BURST_EN
    burst_next   = burst_left;
`endif
    case (state)
      IDLE: begin
`ifdef STEP_BURST_EN
        if (burst_left != '0 && !mode_change) begin
          start      = 1'b1;
          state_next = HIGH;
          burst_next = burst_left - 1'b1;
          if (step_trig && !run_sync) pending_next = 1'b1;
        end else
`endif
        if (trig || (pending && !mode_change)) begin
          start        = 1'b1;
          state_next   = HIGH;
          pending_next = 1'b0;
`ifdef STEP_BURST_EN
          burst_next   = run_sync ? '0 : BUR_W'(BURST_LEN - 1);
`endif
        end
      end
      HIGH:    if (ph_done) state_next = GUARD;
      GUARD:   if (ph_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Presses while a pulse is in flight collapse into a single pending request.
    if (state != IDLE && step_trig && !run_sync) pending_next = 1'b1;
    if (mode_change) begin
      pending_next = 1'b0;
`ifdef STEP_BURST_EN
      burst_next   = '0;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      ph_cnt   <= '0;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      step_cnt <= '0;
`ifdef STEP_BURST_EN
      burst_left <= '0;
`endif
    end else begin
      state   <= state_next;
      pending <= pending_next;
      clk_out <= (state_next == HIGH);
      tick    <= start;
      ph_cnt  <= (state_next != state) ? '0 : ph_cnt + 1'b1;
      if (start) step_cnt <= step_cnt + 16'd1;
`ifdef STEP_BURST_EN
      burst_left <= burst_next;
`endif
    end
  end

  assign ClkOut    = clk_out;
  assign Tick      = tick;
  assign StepCount = step_cnt;
  assign Busy      = (state != IDLE);

endmodule
